ariane_regfile_fi: RTL and testbench
====================================

// Module: ariane_regfile_fi
// PURPOSE
//  Flip-flop integer register file (multi-port R/W) with a built-in fault-injection engine.
//  Generalises the single-bit-flip debug regfile:
//   - parametrised depth
//   - delayed one-shot flips
//   - persistent stuck-at-0/1 faults
//   - valid/ready command handshake and status outputs
//  Drop-in for the ariane issue-stage regfile; the command port is driven by the host debug bridge.
// PARAMETERS
//  DATA_WIDTH      64  register width in bits
//  ADDR_WIDTH      5   address bits; NUM_WORDS = 2**ADDR_WIDTH
//  NR_READ_PORTS   2   combinational read ports
//  NR_WRITE_PORTS  2   write ports
//  ZERO_REG_ZERO   0   1: word 0 reads 0 always, fault commands to it are rejected
//  DELAY_WIDTH     16  width of the injection delay counter
//  BIT_WIDTH       $clog2(DATA_WIDTH)  width of the bit-index field
// PORTS
//  clk_i          in   1                          clock
//  rst_ni         in   1                          async reset, active low
//  test_en_i      in   1                          test mode; no functional effect
//  raddr_i        in   NR_READ_PORTS x ADDR_WIDTH  read addresses
//  rdata_o        out  NR_READ_PORTS x DATA_WIDTH  read data, combinational from storage
//  waddr_i        in   NR_WRITE_PORTS x ADDR_WIDTH write addresses
//  wdata_i        in   NR_WRITE_PORTS x DATA_WIDTH write data
//  we_i           in   NR_WRITE_PORTS              write enables
//  cmd_valid_i    in   1                          fault command valid
//  cmd_ready_o    out  1                          engine can accept a command
//  cmd_op_i       in   3                          0 NOP, 1 FLIP, 2 STUCK0, 3 STUCK1, 4 CLEAR, 5 CLR_CNT
//  cmd_addr_i     in   ADDR_WIDTH                 target word
//  cmd_bit_i      in   BIT_WIDTH                  target bit
//  cmd_delay_i    in   DELAY_WIDTH                cycles from accept to inject
//  done_o         out  1                          1-cycle pulse: command completed
//  err_o          out  1                          valid with done_o: command rejected
//  busy_o         out  1                          command armed or injecting
//  inject_cnt_o   out  16                         saturating count of applied faults
//  stuck_any_o    out  1                          OR of all stuck masks
//  cnt_sel_i      in   ADDR_WIDTH                 write-counter readout select
//  cnt_o          out  16                         write counter of word cnt_sel_i
// BEHAVIOUR
//  Reset: all storage, masks and counters = 0. FSM = IDLE; cmd_ready_o=1; all other outputs 0.
//  Write path:
//   - per word, highest-index write port with a matching enabled address wins
//   - stored value = (wdata & ~sa0[w]) | sa1[w]; read data has zero latency
//  Handshake: accept on cmd_valid_i & cmd_ready_o; cmd_ready_o=1 only in IDLE.
//   Op/addr/bit/delay are latched at accept.
//  FSM (3 states):
//   - IDLE -accept-> ARMED; ctr = cmd_delay_i
//   - ARMED: ctr decrements each cycle; ctr==0 -> INJECT
//   - INJECT: apply op, pulse done_o, -> IDLE
//   - delay 0: inject in the 2nd cycle after accept (ARMED 1 cycle)
//   - delay N: inject N+1 cycles after the ARMED entry
//  Ops:
//   - FLIP: invert bit in mem[addr]. If a write to addr occurs in the same cycle, the flip
//     applies to the written value.
//   - STUCK0 / STUCK1: set the bit in sa0/sa1 and clear it in the other mask; force the bit
//     in the stored word immediately.
//   - CLEAR: zero both masks; storage is unchanged.
//   - CLR_CNT: zero inject_cnt_o and the write counters.
//   - NOP: completes with done_o only.
//  Counting: FLIP/STUCK0/STUCK1 increment inject_cnt_o, saturating at 16'hFFFF.
//  Reject (err_o=1, done_o=1, no state change):
//   - cmd_bit_i >= DATA_WIDTH
//   - op > 5
//   - fault op to word 0 when ZERO_REG_ZERO
//   Rejection is evaluated in INJECT, i.e. same latency as a valid command.
//  Reset mid-operation (rst_ni low in any state) aborts the pending command; no done_o.
//  busy_o = (state != IDLE). stuck_any_o = |sa0 | |sa1, registered from the masks.
// CONFIGURATION
//  REGFILE_FI_WR_CNT_EN defined:
//   - one 16-bit saturating counter per word, incremented on each winning write
//   - CLR_CNT clears all counters
//   - cnt_o = counter[cnt_sel_i], combinational
//  Not defined: counters not built; cnt_o tied to 0.
// TESTING
//  T1: write x5 = 64'hA5 via port 0 and x5 = 64'h3C via port 1 in the same cycle
//      -> rdata x5 = 64'h3C next cycle.
//  T2: FLIP addr 7, bit 3, delay 0, x7 = 0 -> done_o 2 cycles after accept; x7 = 64'h8;
//      inject_cnt_o = 1.
//  T3: STUCK1 addr 9, bit 0, then write x9 = 64'h10 -> x9 = 64'h11;
//      CLEAR, rewrite 64'h10 -> x9 = 64'h10; stuck_any_o 1 then 0.
//  T4: FLIP delay 10, assert cmd_valid_i while armed -> cmd_ready_o = 0, busy_o = 1;
//      inject exactly 11 cycles after ARMED entry; second command accepted after done_o.
//  T5: FLIP bit 64 (DATA_WIDTH 64); and ZERO_REG_ZERO=1 with STUCK1 addr 0
//      -> done_o & err_o, storage and inject_cnt_o unchanged.
//  T6: accept FLIP delay 5, pull rst_ni low on cycle 2 -> no done_o; all words 0;
//      cmd_ready_o = 1 after release.

Source files
------------

// File: rtl/ariane_regfile_fi.sv
`default_nettype none
// ============================================================================
// Module   : ariane_regfile_fi
// Purpose  : Flip-flop register file with delayed flip and stuck-at fault
//            injection engine. Optional per-word write counters: REGFILE_FI_WR_CNT_EN
// Revision : 1.0 - initial release
// ============================================================================
module ariane_regfile_fi #(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned ADDR_WIDTH     = 5,
    parameter int unsigned NR_READ_PORTS  = 2,
    parameter int unsigned NR_WRITE_PORTS = 2,
    parameter bit          ZERO_REG_ZERO  = 1'b0,
    parameter int unsigned DELAY_WIDTH    = 16,
    parameter int unsigned BIT_WIDTH      = $clog2(DATA_WIDTH)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      test_en_i,
    input  logic [ADDR_WIDTH-1:0]     raddr_i [NR_READ_PORTS],
    output logic [DATA_WIDTH-1:0]     rdata_o [NR_READ_PORTS],
    input  logic [ADDR_WIDTH-1:0]     waddr_i [NR_WRITE_PORTS],
    input  logic [DATA_WIDTH-1:0]     wdata_i [NR_WRITE_PORTS],
    input  logic [NR_WRITE_PORTS-1:0] we_i,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic [2:0]                cmd_op_i,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr_i,
    input  logic [BIT_WIDTH-1:0]      cmd_bit_i,
    input  logic [DELAY_WIDTH-1:0]    cmd_delay_i,
    output logic                      done_o,
    output logic                      err_o,
    output logic                      busy_o,
    output logic [15:0]               inject_cnt_o,
    output logic                      stuck_any_o,
    input  logic [ADDR_WIDTH-1:0]     cnt_sel_i,
    output logic [15:0]               cnt_o
);
    localparam int unsigned NUM_WORDS = 2**ADDR_WIDTH;

    localparam logic [2:0] c_op_flip    = 3'd1;
    localparam logic [2:0] c_op_stuck0  = 3'd2;
    localparam logic [2:0] c_op_stuck1  = 3'd3;
    localparam logic [2:0] c_op_clear   = 3'd4;
    localparam logic [2:0] c_op_clr_cnt = 3'd5;

    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, INJECT = 2'd2} state_e;

    state_e                  r_state;
    logic [2:0]              r_op;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [BIT_WIDTH-1:0]    r_bit;
    logic [DELAY_WIDTH-1:0]  r_ctr;
    logic                    r_done;
    logic                    r_err;
    logic [15:0]             r_inject_cnt;
    logic                    r_stuck_any;

    logic [DATA_WIDTH-1:0]   w_mem [NUM_WORDS];
    logic [NUM_WORDS-1:0]    w_stuck_word;
    logic [DATA_WIDTH-1:0]   w_bit_mask;
    logic                    w_fault_op;
    logic                    w_reject;
    logic                    w_apply;
    logic                    w_clr_cnt;

    assign w_bit_mask = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << r_bit;
    assign w_fault_op = (r_op == c_op_flip) || (r_op == c_op_stuck0) || (r_op == c_op_stuck1);
    assign w_reject   = (32'(r_bit) >= DATA_WIDTH) || (r_op > c_op_clr_cnt) ||
                        (ZERO_REG_ZERO && w_fault_op && (r_addr == '0));
    assign w_apply    = (r_state == INJECT) && !w_reject;
    assign w_clr_cnt  = w_apply && (r_op == c_op_clr_cnt);

    // Command fields are latched at accept; later changes on the bus are ignored.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_op    <= '0;
            r_addr  <= '0;
            r_bit   <= '0;
            r_ctr   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        r_op    <= cmd_op_i;
                        r_addr  <= cmd_addr_i;
                        r_bit   <= cmd_bit_i;
                        r_ctr   <= cmd_delay_i;
                        r_state <= ARMED;
                    end
                end
                ARMED: begin
                    if (r_ctr == '0) begin
                        r_state <= INJECT;
                        r_done  <= 1'b1;
                        r_err   <= w_reject;
                    end else begin
                        r_ctr <= r_ctr - 1'b1;
                    end
                end
                INJECT:  r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_inject_cnt <= '0;
            r_stuck_any  <= 1'b0;
        end else begin
            r_stuck_any <= |w_stuck_word;
            if (w_clr_cnt)
                r_inject_cnt <= '0;
            else if (w_apply && w_fault_op && (r_inject_cnt != 16'hFFFF))
                r_inject_cnt <= r_inject_cnt + 16'd1;
        end
    end

`ifdef REGFILE_FI_WR_CNT_EN
    logic [15:0] w_wr_cnt [NUM_WORDS];
`endif

    for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
        logic [DATA_WIDTH-1:0] r_mem;
        logic [DATA_WIDTH-1:0] r_sa0;
        logic [DATA_WIDTH-1:0] r_sa1;
        logic                  w_we;
        logic [DATA_WIDTH-1:0] w_wdata;
        logic [DATA_WIDTH-1:0] w_base;
        logic [DATA_WIDTH-1:0] w_sa0_d;
        logic [DATA_WIDTH-1:0] w_sa1_d;
        logic                  w_hit;

        // Later ports override earlier ones on an address collision.
        always_comb begin
            w_we    = 1'b0;
            w_wdata = '0;
            for (int p = 0; p < NR_WRITE_PORTS; p++) begin
                if (we_i[p] && (waddr_i[p] == ADDR_WIDTH'(w))) begin
                    w_we    = 1'b1;
                    w_wdata = wdata_i[p];
                end
            end
        end

        assign w_hit = w_apply && (r_addr == ADDR_WIDTH'(w));

        // Masks are applied with their next value so a new stuck-at forces the word at once.
        always_comb begin
            w_base  = w_we ? w_wdata : r_mem;
            w_sa0_d = r_sa0;
            w_sa1_d = r_sa1;
            if (w_apply && (r_op == c_op_clear)) begin
                w_sa0_d = '0;
                w_sa1_d = '0;
            end
            if (w_hit) begin
                case (r_op)
                    c_op_flip:   w_base = w_base ^ w_bit_mask;
                    c_op_stuck0: begin
                        w_sa0_d = w_sa0_d | w_bit_mask;
                        w_sa1_d = w_sa1_d & ~w_bit_mask;
                    end
                    c_op_stuck1: begin
                        w_sa1_d = w_sa1_d | w_bit_mask;
                        w_sa0_d = w_sa0_d & ~w_bit_mask;
                    end
                    default: ;
                endcase
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_mem <= '0;
                r_sa0 <= '0;
                r_sa1 <= '0;
            end else begin
                r_mem <= (w_base & ~w_sa0_d) | w_sa1_d;
                r_sa0 <= w_sa0_d;
                r_sa1 <= w_sa1_d;
            end
        end

        assign w_mem[w]        = r_mem;
        assign w_stuck_word[w] = (|r_sa0) | (|r_sa1);

`ifdef REGFILE_FI_WR_CNT_EN
        logic [15:0] r_wr_cnt;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni)
                r_wr_cnt <= '0;
            else if (w_clr_cnt)
                r_wr_cnt <= '0;
            else if (w_we && (r_wr_cnt != 16'hFFFF))
                r_wr_cnt <= r_wr_cnt + 16'd1;
        end
        assign w_wr_cnt[w] = r_wr_cnt;
`endif
    end

    for (genvar p = 0; p < NR_READ_PORTS; p++) begin : g_read
        assign rdata_o[p] = (ZERO_REG_ZERO && (raddr_i[p] == '0)) ? '0 : w_mem[raddr_i[p]];
    end

`ifdef REGFILE_FI_WR_CNT_EN
    assign cnt_o = w_wr_cnt[cnt_sel_i];
    logic w_unused;
    assign w_unused = test_en_i;
`else
    assign cnt_o = 16'd0;
    logic w_unused;
    assign w_unused = test_en_i ^ (|cnt_sel_i);
`endif

    assign cmd_ready_o  = (r_state == IDLE);
    assign busy_o       = (r_state != IDLE);
    assign done_o       = r_done;
    assign err_o        = r_err;
    assign inject_cnt_o = r_inject_cnt;
    assign stuck_any_o  = r_stuck_any;

endmodule
`default_nettype wire

// File: tb/tb_ariane_regfile_fi.sv
`default_nettype none
// ============================================================================
// Module   : tb_ariane_regfile_fi
// Purpose  : Directed self-checking bench for ariane_regfile_fi
// Revision : 1.0 - initial release
// ============================================================================
module tb_ariane_regfile_fi;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        test_en_i;
    logic [4:0]  raddr [2];
    logic [63:0] rdata [2];
    logic [4:0]  waddr [2];
    logic [63:0] wdata [2];
    logic [1:0]  we;
    logic        cmd_valid, cmd_ready, done, err, busy, stuck_any;
    logic [2:0]  cmd_op;
    logic [4:0]  cmd_addr, cnt_sel;
    logic [6:0]  cmd_bit;
    logic [15:0] cmd_delay, inject_cnt, cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_inj = 0;

    localparam logic [2:0] NOP = 3'd0, FLIP = 3'd1, STUCK0 = 3'd2, STUCK1 = 3'd3,
                           CLEAR = 3'd4, CLR_CNT = 3'd5;

    ariane_regfile_fi #(
        .DATA_WIDTH(64), .ADDR_WIDTH(5), .NR_READ_PORTS(2), .NR_WRITE_PORTS(2),
        .ZERO_REG_ZERO(1'b1), .DELAY_WIDTH(16), .BIT_WIDTH(7)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .test_en_i(test_en_i),
        .raddr_i(raddr), .rdata_o(rdata), .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
        .cmd_addr_i(cmd_addr), .cmd_bit_i(cmd_bit), .cmd_delay_i(cmd_delay),
        .done_o(done), .err_o(err), .busy_o(busy), .inject_cnt_o(inject_cnt),
        .stuck_any_o(stuck_any), .cnt_sel_i(cnt_sel), .cnt_o(cnt)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input int port, input int addr, input logic [63:0] data);
        we[port] = 1'b1; waddr[port] = 5'(addr); wdata[port] = data;
        tick();
        we = 2'b00;
    endtask

    task automatic rd(input int addr, output logic [63:0] data);
        raddr[0] = 5'(addr);
        #1;
        data = rdata[0];
    endtask

    // Issues a command from IDLE; lat = cycles from accept edge to done_o (-1 on timeout).
    task automatic run_cmd(input logic [2:0] op, input int addr, input int bitn, input int delay,
                           output int lat, output logic e);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = 5'(addr); cmd_bit = 7'(bitn);
        cmd_delay = 16'(delay);
        tick();
        cmd_valid = 1'b0;
        lat = -1; e = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            if (done) begin lat = i; e = err; break; end
            tick();
        end
        if (lat >= 0) tick();
    endtask

    task automatic test_reset();
        logic [63:0] d;
        n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
        n_chk++; if ({done, err, busy, stuck_any} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {done, err, busy, stuck_any}); end
        n_chk++; if (inject_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", inject_cnt); end
        rd(17, d);
        n_chk++; if (d !== 64'd0) begin n_fail++; $display("FAIL reset_mem: got %h want 0", d); end
    endtask

    task automatic test_write_priority();
        logic [63:0] d;
        logic [15:0] exp_wc;
        we = 2'b11; waddr[0] = 5'd5; wdata[0] = 64'hA5; waddr[1] = 5'd5; wdata[1] = 64'h3C;
        tick();
        we = 2'b00;
        rd(5, d);
        n_chk++; if (d !== 64'h3C) begin n_fail++; $display("FAIL t1_prio: got %h want %h", d, 64'h3C); end
        raddr[1] = 5'd5; #1;
        n_chk++; if (rdata[1] !== 64'h3C) begin n_fail++; $display("FAIL t1_port1: got %h want %h", rdata[1], 64'h3C); end
        wr(0, 0, 64'hFF);
        rd(0, d);
        n_chk++; if (d !== 64'd0) begin n_fail++; $display("FAIL zero_reg: got %h want 0", d); end
`ifdef REGFILE_FI_WR_CNT_EN
        exp_wc = 16'd1;
`else
        exp_wc = 16'd0;
`endif
        cnt_sel = 5'd5; #1;
        n_chk++; if (cnt !== exp_wc) begin n_fail++; $display("FAIL wr_cnt: got %0d want %0d", cnt, exp_wc); end
    endtask

    task automatic test_flip();
        logic [63:0] d;
        int lat;
        logic e;
        run_cmd(FLIP, 7, 3, 0, lat, e);
        exp_inj++;
        n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL t2_latency: got %0d want 2", lat); end
        n_chk++; if (e !== 1'b0) begin n_fail++; $display("FAIL t2_err: got %b want 0", e); end
        rd(7, d);
        n_chk++; if (d !== 64'h8) begin n_fail++; $display("FAIL t2_data: got %h want %h", d, 64'h8); end
        n_chk++; if (inject_cnt !== 16'(exp_inj)) begin n_fail++; $display("FAIL t2_cnt: got %0d want %0d", inject_cnt, exp_inj); end
        // Flip coincident with a write to the same word lands on the written value.
        cmd_valid = 1'b1; cmd_op = FLIP; cmd_addr = 5'd10; cmd_bit = 7'd1; cmd_delay = 16'd0;
        tick();
        cmd_valid = 1'b0;
        n_chk++; if ({cmd_ready, busy, done} !== 3'b010) begin n_fail++; $display("FAIL armed_flags: got %b want 010", {cmd_ready, busy, done}); end
        tick();
        n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL inject_done: got %b want 1", done); end
        wr(0, 10, 64'h100);
        exp_inj++;
        rd(10, d);
        n_chk++; if (d !== 64'h102) begin n_fail++; $display("FAIL flip_with_write: got %h want %h", d, 64'h102); end
        n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse: got %b want 0", done); end
    endtask

    task automatic test_stuck();
        logic [63:0] d;
        int lat;
        logic e;
        run_cmd(STUCK1, 9, 0, 0, lat, e);
        exp_inj++;
        rd(9, d);
        n_chk++; if (d !== 64'h1) begin n_fail++; $display("FAIL t3_force: got %h want 1", d); end
        tick();
        n_chk++; if (stuck_any !== 1'b1) begin n_fail++; $display("FAIL t3_stuck_any_set: got %b want 1", stuck_any); end
        wr(0, 9, 64'h10);
        rd(9, d);
        n_chk++; if (d !== 64'h11) begin n_fail++; $display("FAIL t3_sa1_write: got %h want %h", d, 64'h11); end
        wr(1, 11, 64'hFF);
        run_cmd(STUCK0, 11, 0, 0, lat, e);
        exp_inj++;
        wr(0, 11, 64'hFF);
        rd(11, d);
        n_chk++; if (d !== 64'hFE) begin n_fail++; $display("FAIL sa0_write: got %h want %h", d, 64'hFE); end
        run_cmd(STUCK1, 11, 0, 0, lat, e);
        exp_inj++;
        rd(11, d);
        n_chk++; if (d !== 64'hFF) begin n_fail++; $display("FAIL sa1_replaces_sa0: got %h want %h", d, 64'hFF); end
        run_cmd(CLEAR, 9, 0, 0, lat, e);
        rd(9, d);
        n_chk++; if (d !== 64'h11) begin n_fail++; $display("FAIL clear_keeps_data: got %h want %h", d, 64'h11); end
        wr(0, 9, 64'h10);
        rd(9, d);
        n_chk++; if (d !== 64'h10) begin n_fail++; $display("FAIL t3_after_clear: got %h want %h", d, 64'h10); end
        n_chk++; if (stuck_any !== 1'b0) begin n_fail++; $display("FAIL t3_stuck_any_clr: got %b want 0", stuck_any); end
        n_chk++; if (inject_cnt !== 16'(exp_inj)) begin n_fail++; $display("FAIL stuck_cnt: got %0d want %0d", inject_cnt, exp_inj); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] d;
        int lat;
        cmd_valid = 1'b1; cmd_op = FLIP; cmd_addr = 5'd12; cmd_bit = 7'd5; cmd_delay = 16'd10;
        tick();
        // Keep valid high with different fields while armed; they must be ignored.
        cmd_bit = 7'd6; cmd_delay = 16'd0;
        n_chk++; if ({cmd_ready, busy} !== 2'b01) begin n_fail++; $display("FAIL t4_armed: got %b want 01", {cmd_ready, busy}); end
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            if (done) begin lat = i; break; end
            tick();
        end
        n_chk++; if (lat !== 12) begin n_fail++; $display("FAIL t4_latency: got %0d want 12", lat); end
        tick();
        exp_inj++;
        rd(12, d);
        n_chk++; if (d !== 64'h20) begin n_fail++; $display("FAIL t4_first: got %h want %h", d, 64'h20); end
        n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL t4_ready: got %b want 1", cmd_ready); end
        tick();
        cmd_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            if (done) begin lat = i; break; end
            tick();
        end
        tick();
        exp_inj++;
        n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL t4_second_lat: got %0d want 2", lat); end
        rd(12, d);
        n_chk++; if (d !== 64'h60) begin n_fail++; $display("FAIL t4_second: got %h want %h", d, 64'h60); end
    endtask

    task automatic test_reject();
        logic [63:0] d;
        int lat;
        logic e;
        run_cmd(FLIP, 13, 64, 0, lat, e);
        n_chk++; if ({lat == 2, e} !== 2'b11) begin n_fail++; $display("FAIL t5_bit64: got lat %0d err %b want lat 2 err 1", lat, e); end
        rd(13, d);
        n_chk++; if (d !== 64'd0) begin n_fail++; $display("FAIL t5_bit64_data: got %h want 0", d); end
        run_cmd(STUCK1, 0, 0, 0, lat, e);
        n_chk++; if ({lat == 2, e} !== 2'b11) begin n_fail++; $display("FAIL t5_zero_reg: got lat %0d err %b want lat 2 err 1", lat, e); end
        tick();
        n_chk++; if (stuck_any !== 1'b0) begin n_fail++; $display("FAIL t5_stuck_any: got %b want 0", stuck_any); end
        run_cmd(3'd6, 14, 0, 0, lat, e);
        n_chk++; if (e !== 1'b1) begin n_fail++; $display("FAIL bad_op: got err %b want 1", e); end
        run_cmd(NOP, 0, 0, 0, lat, e);
        n_chk++; if ({lat == 2, e} !== 2'b10) begin n_fail++; $display("FAIL nop: got lat %0d err %b want lat 2 err 0", lat, e); end
        n_chk++; if (inject_cnt !== 16'(exp_inj)) begin n_fail++; $display("FAIL t5_cnt: got %0d want %0d", inject_cnt, exp_inj); end
        run_cmd(CLR_CNT, 0, 0, 0, lat, e);
        exp_inj = 0;
        cnt_sel = 5'd5; #1;
        n_chk++; if ({inject_cnt, cnt} !== 32'd0) begin n_fail++; $display("FAIL clr_cnt: got %0d/%0d want 0/0", inject_cnt, cnt); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] d;
        logic seen;
        wr(0, 14, 64'h77);
        cmd_valid = 1'b1; cmd_op = FLIP; cmd_addr = 5'd14; cmd_bit = 7'd0; cmd_delay = 16'd5;
        tick();
        cmd_valid = 1'b0;
        tick();
        rst_ni = 1'b0;
        #1;
        n_chk++; if ({cmd_ready, busy} !== 2'b10) begin n_fail++; $display("FAIL t6_async: got %b want 10", {cmd_ready, busy}); end
        rd(14, d);
        n_chk++; if (d !== 64'd0) begin n_fail++; $display("FAIL t6_mem: got %h want 0", d); end
        tick(); tick();
        rst_ni = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            seen = seen | done;
            tick();
        end
        n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL t6_no_done: got %b want 0", seen); end
        rd(14, d);
        n_chk++; if ({cmd_ready, d} !== {1'b1, 64'd0}) begin n_fail++; $display("FAIL t6_after: got ready %b data %h want 1/0", cmd_ready, d); end
    endtask

    initial begin
        rst_ni = 1'b0; test_en_i = 1'b0; we = 2'b00; cmd_valid = 1'b0;
        cmd_op = '0; cmd_addr = '0; cmd_bit = '0; cmd_delay = '0; cnt_sel = '0;
        raddr[0] = '0; raddr[1] = '0; waddr[0] = '0; waddr[1] = '0;
        wdata[0] = '0; wdata[1] = '0;
        tick(); tick(); tick();
        rst_ni = 1'b1;
        tick();
        test_reset();
        test_write_priority();
        test_flip();
        test_stuck();
        test_back_to_back();
        test_reject();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
`default_nettype wire
